// File: rtl/wb_regfile.sv
// Write-back select, 32-entry architectural register file with same-cycle bypass,
// and debug taps recording the most recent commit and a running commit count.
module wb_regfile #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_REGS = 32,
    localparam int unsigned IdxW    = $clog2(NUM_REGS)
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              RegWrite_in,
    input  logic [1:0]        MemReg_in,
    input  logic [DATA_W-1:0] ReadData_in,
    input  logic [DATA_W-1:0] ALUResult_in,
    input  logic [DATA_W-1:0] PC2ndAdder_in,
    input  logic [31:0]       RtRd_in,
    input  logic [IdxW-1:0]   ReadRegister1,
    input  logic [IdxW-1:0]   ReadRegister2,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2,
    output logic [DATA_W-1:0] WriteData_out,
    output logic [IdxW-1:0]   LastWriteReg,
    output logic [DATA_W-1:0] LastWriteData,
    output logic [31:0]       CommitCount
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [IdxW-1:0]   last_reg_q;
    logic [DATA_W-1:0] last_data_q;
    logic [31:0]       count_q;

    logic [IdxW-1:0] waddr;
    logic            commit;
    logic            unused_rtrd_hi;

    assign waddr          = RtRd_in[IdxW-1:0];
    assign unused_rtrd_hi = ^RtRd_in[31:IdxW];
    assign commit         = RegWrite_in && (waddr != '0);

    always_comb begin
        case (MemReg_in)
            2'b01:   WriteData_out = ReadData_in;
            2'b10:   WriteData_out = PC2ndAdder_in;
            default: WriteData_out = ALUResult_in;
        endcase
    end

    // Bypass is gated by Rst so reads return zero for the whole reset window.
    always_comb begin
        if (ReadRegister1 == '0) begin
            ReadData1 = '0;
        end else if (Rst && commit && (waddr == ReadRegister1)) begin
            ReadData1 = WriteData_out;
        end else begin
            ReadData1 = regs_q[ReadRegister1];
        end
    end

    always_comb begin
        if (ReadRegister2 == '0) begin
            ReadData2 = '0;
        end else if (Rst && commit && (waddr == ReadRegister2)) begin
            ReadData2 = WriteData_out;
        end else begin
            ReadData2 = regs_q[ReadRegister2];
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= '0;
            end
            last_reg_q  <= '0;
            last_data_q <= '0;
            count_q     <= '0;
        end else if (commit) begin
            regs_q[waddr] <= WriteData_out;
            last_reg_q    <= waddr;
            last_data_q   <= WriteData_out;
            count_q       <= count_q + 32'd1;
        end
    end

    assign LastWriteReg  = last_reg_q;
    assign LastWriteData = last_data_q;
    assign CommitCount   = count_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: reset sweep, vector table, bypass and reset sequences,
// then randomized traffic checked against an array-based register model.
module tb_wb_regfile;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        RegWrite_in;
    logic [1:0]  MemReg_in;
    logic [31:0] ReadData_in;
    logic [31:0] ALUResult_in;
    logic [31:0] PC2ndAdder_in;
    logic [31:0] RtRd_in;
    logic [4:0]  ReadRegister1;
    logic [4:0]  ReadRegister2;
    logic [31:0] ReadData1;
    logic [31:0] ReadData2;
    logic [31:0] WriteData_out;
    logic [4:0]  LastWriteReg;
    logic [31:0] LastWriteData;
    logic [31:0] CommitCount;

    int errors = 0;
    int checks = 0;

    wb_regfile dut (
        .Clk           (Clk),
        .Rst           (Rst),
        .RegWrite_in   (RegWrite_in),
        .MemReg_in     (MemReg_in),
        .ReadData_in   (ReadData_in),
        .ALUResult_in  (ALUResult_in),
        .PC2ndAdder_in (PC2ndAdder_in),
        .RtRd_in       (RtRd_in),
        .ReadRegister1 (ReadRegister1),
        .ReadRegister2 (ReadRegister2),
        .ReadData1     (ReadData1),
        .ReadData2     (ReadData2),
        .WriteData_out (WriteData_out),
        .LastWriteReg  (LastWriteReg),
        .LastWriteData (LastWriteData),
        .CommitCount   (CommitCount)
    );

    always #5 Clk = ~Clk;

    // Reference model: architectural state as plain arrays and counters.
    logic [31:0] m_regs [32];
    int unsigned m_count;
    logic [4:0]  m_last_reg;
    logic [31:0] m_last_data;

    typedef struct {
        logic        rw;
        logic [1:0]  mr;
        logic [31:0] rtrd;
        logic [31:0] alu;
        logic [31:0] ld;
        logic [31:0] pc;
        logic [4:0]  rreg;
        logic [31:0] exp_wd;
        logic [31:0] exp_rd;
        logic [31:0] exp_cnt;
        logic [4:0]  exp_last;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_wd();
        if (MemReg_in == 2'd1) return ReadData_in;
        if (MemReg_in == 2'd2) return PC2ndAdder_in;
        return ALUResult_in;
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] r);
        logic [4:0] w;
        w = RtRd_in[4:0];
        if (r == 5'd0) return 32'd0;
        if (RegWrite_in && w != 5'd0 && w == r) return model_wd();
        return m_regs[r];
    endfunction

    task automatic model_edge();
        logic [4:0] w;
        w = RtRd_in[4:0];
        if (RegWrite_in && w != 5'd0) begin
            m_regs[w]   = model_wd();
            m_last_reg  = w;
            m_last_data = model_wd();
            m_count     = m_count + 1;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_count     = 0;
        m_last_reg  = 5'd0;
        m_last_data = 32'd0;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic rw, input logic [1:0] mr, input logic [31:0] rt,
                         input logic [31:0] alu, input logic [31:0] ld, input logic [31:0] pc);
        RegWrite_in   = rw;
        MemReg_in     = mr;
        RtRd_in       = rt;
        ALUResult_in  = alu;
        ReadData_in   = ld;
        PC2ndAdder_in = pc;
    endtask

    initial begin
        Rst           = 1'b0;
        ReadRegister1 = 5'd0;
        ReadRegister2 = 5'd0;
        drive(1'b1, 2'd0, 32'd7, 32'd123, 32'd0, 32'd0);
        model_reset();

        // Reset held across several edges with a write request present.
        repeat (3) tick();
        check("reset_wd_mux", WriteData_out, 32'd123);
        for (int i = 0; i < 32; i++) begin
            ReadRegister1 = 5'(i);
            ReadRegister2 = 5'(31 - i);
            #1;
            check("reset_rd1", ReadData1, 32'd0);
            check("reset_rd2", ReadData2, 32'd0);
        end
        check("reset_count", CommitCount, 32'd0);
        check("reset_lastreg", {27'd0, LastWriteReg}, 32'd0);
        check("reset_lastdata", LastWriteData, 32'd0);

        drive(1'b0, 2'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        Rst = 1'b1;
        tick();

        vecs[0] = '{1'b1, 2'd0, 32'd5, 32'h11, 32'h22, 32'h33, 5'd5, 32'h11, 32'h11, 32'd1, 5'd5};
        vecs[1] = '{1'b1, 2'd1, 32'd5, 32'h11, 32'h22, 32'h33, 5'd5, 32'h22, 32'h22, 32'd2, 5'd5};
        vecs[2] = '{1'b1, 2'd2, 32'd5, 32'h11, 32'h22, 32'h33, 5'd5, 32'h33, 32'h33, 32'd3, 5'd5};
        vecs[3] = '{1'b1, 2'd3, 32'd5, 32'h11, 32'h22, 32'h33, 5'd5, 32'h11, 32'h11, 32'd4, 5'd5};
        vecs[4] = '{1'b1, 2'd0, 32'd0, 32'hDEADBEEF, 32'h0, 32'h0, 5'd0, 32'hDEADBEEF, 32'h0,
                    32'd4, 5'd5};
        vecs[5] = '{1'b1, 2'd1, 32'hFFFFFFE3, 32'h0, 32'h77, 32'h0, 5'd3, 32'h77, 32'h77,
                    32'd5, 5'd3};
        vecs[6] = '{1'b0, 2'd0, 32'd3, 32'h99, 32'h0, 32'h0, 5'd3, 32'h99, 32'h77, 32'd5, 5'd3};

        for (int v = 0; v < 7; v++) begin
            drive(vecs[v].rw, vecs[v].mr, vecs[v].rtrd, vecs[v].alu, vecs[v].ld, vecs[v].pc);
            ReadRegister1 = vecs[v].rreg;
            ReadRegister2 = vecs[v].rreg;
            #1;
            check($sformatf("vec%0d_wd", v), WriteData_out, vecs[v].exp_wd);
            model_edge();
            tick();
            drive(1'b0, 2'd0, 32'd0, 32'd0, 32'd0, 32'd0);
            #1;
            check($sformatf("vec%0d_rd1", v), ReadData1, vecs[v].exp_rd);
            check($sformatf("vec%0d_rd2", v), ReadData2, vecs[v].exp_rd);
            check($sformatf("vec%0d_cnt", v), CommitCount, vecs[v].exp_cnt);
            check($sformatf("vec%0d_last", v), {27'd0, LastWriteReg}, {27'd0, vecs[v].exp_last});
        end

        // Same-cycle bypass on both ports over an older stored value.
        drive(1'b1, 2'd0, 32'd8, 32'hAAAA, 32'd0, 32'd0);
        model_edge();
        tick();
        drive(1'b1, 2'd0, 32'd8, 32'h5555, 32'd0, 32'd0);
        ReadRegister1 = 5'd8;
        ReadRegister2 = 5'd8;
        #1;
        check("bypass_pre_rd1", ReadData1, 32'h5555);
        check("bypass_pre_rd2", ReadData2, 32'h5555);
        model_edge();
        tick();
        drive(1'b0, 2'd0, 32'd8, 32'h0, 32'd0, 32'd0);
        #1;
        check("bypass_post_rd1", ReadData1, 32'h5555);
        check("bypass_post_rd2", ReadData2, 32'h5555);
        check("bypass_cnt", CommitCount, 32'd7);
        check("bypass_lastdata", LastWriteData, 32'h5555);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            logic [31:0] rt;
            rt = $urandom();
            drive(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), rt,
                  $urandom(), $urandom(), $urandom());
            ReadRegister1 = ($urandom_range(0, 2) == 0) ? rt[4:0] : 5'($urandom_range(0, 31));
            ReadRegister2 = ($urandom_range(0, 2) == 0) ? rt[4:0] : 5'($urandom_range(0, 31));
            #1;
            check("rand_wd", WriteData_out, model_wd());
            check("rand_rd1", ReadData1, model_read(ReadRegister1));
            check("rand_rd2", ReadData2, model_read(ReadRegister2));
            model_edge();
            tick();
            check("rand_cnt", CommitCount, m_count);
            check("rand_lastreg", {27'd0, LastWriteReg}, {27'd0, m_last_reg});
            check("rand_lastdata", LastWriteData, m_last_data);
        end

        // Asynchronous reset between edges, with a bypass candidate presented.
        drive(1'b1, 2'd0, 32'd4, 32'h4444, 32'd0, 32'd0);
        ReadRegister1 = 5'd4;
        ReadRegister2 = 5'd8;
        #1;
        Rst = 1'b0;
        model_reset();
        #1;
        check("areset_rd1_bypass", ReadData1, 32'd0);
        check("areset_rd2", ReadData2, 32'd0);
        check("areset_cnt", CommitCount, 32'd0);
        check("areset_lastreg", {27'd0, LastWriteReg}, 32'd0);
        check("areset_lastdata", LastWriteData, 32'd0);
        check("areset_wd_mux", WriteData_out, 32'h4444);
        #1;
        Rst = 1'b1;
        drive(1'b1, 2'd0, 32'd2, 32'h1, 32'd0, 32'd0);
        ReadRegister1 = 5'd2;
        ReadRegister2 = 5'd4;
        tick();
        drive(1'b0, 2'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        #1;
        check("release_cnt", CommitCount, 32'd1);
        check("release_rd1", ReadData1, 32'h1);
        check("release_rd2", ReadData2, 32'd0);
        check("release_lastreg", {27'd0, LastWriteReg}, 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Write-back stage and architectural register file for the five-stage MIPS datapath. Consumes the registered outputs of the MEM/WB pipeline register and selects the write-back value: ALU result, load data, or link address. Commits that value into a 32×32 register file and serves the two combinational read ports used by the ID stage. Provides same-cycle write-to-read bypass and debug taps (last write, commit counter).

## Interface

Parameters:
- DATA_W, 32, register and data width
- NUM_REGS, 32, number of architectural registers; index width is log2(NUM_REGS)=5

Ports:
- Clk  in  1  pipeline clock; all state updates on rising edge
- Rst  in  1  asynchronous, active-low reset; clears all state immediately while low
- RegWrite_in  in  1  write enable from MEM/WB
- MemReg_in  in  2  write-back select from MEM/WB
- ReadData_in  in  32  load data from MEM/WB
- ALUResult_in  in  32  ALU result from MEM/WB
- PC2ndAdder_in  in  32  link address (jal) from MEM/WB
- RtRd_in  in  32  destination register index from MEM/WB; bits [4:0] used, [31:5] ignored
- ReadRegister1  in  5  read port 1 index (rs)
- ReadRegister2  in  5  read port 2 index (rt)
- ReadData1  out  32  read port 1 data, combinational
- ReadData2  out  32  read port 2 data, combinational
- WriteData_out  out  32  muxed write-back value, combinational (to forwarding unit)
- LastWriteReg  out  5  index of most recent committed write, registered
- LastWriteData  out  32  data of most recent committed write, registered
- CommitCount  out  32  number of committed writes since reset, registered

## Operation

- Write-back mux (combinational): MemReg_in 2'b00 → ALUResult_in; 2'b01 → ReadData_in; 2'b10 → PC2ndAdder_in; 2'b11 → ALUResult_in (reserved, same as 00).
- Write address waddr = RtRd_in[4:0].
- Commit condition: RegWrite_in==1 and waddr!=0. On a rising Clk edge with Rst high and commit condition true:
  - regs[waddr] ← WriteData_out
  - LastWriteReg ← waddr
  - LastWriteData ← WriteData_out
  - CommitCount ← CommitCount+1, wrapping 0xFFFFFFFF→0
- RegWrite_in==1 with waddr==0: no state change of any kind; register 0 stays zero, counter and debug outputs unchanged.
- Register 0 is hardwired: any read of index 0 returns 0 regardless of stored contents or bypass.
- Read ports (combinational, per port, index r):
  - r==0 → 0
  - else if the commit condition holds and waddr==r → WriteData_out (bypass)
  - else → regs[r]
- The bypass replaces half-cycle write/read. An instruction in ID reading a register that WB writes in the same cycle sees the new value.
- Both read ports are independent; both may bypass simultaneously when they name the same register.

## Timing

- Reset: while Rst==0, all 32 registers, LastWriteReg, LastWriteData and CommitCount are 0 asynchronously, with no Clk required. ReadData1/ReadData2 then return 0 for any index, because the bypass path is also gated by Rst==1. WriteData_out still reflects the mux, since it is combinational.
- Reset release: the first rising edge with Rst==1 may commit.
- Reset asserted mid-operation: any write in flight on that edge is lost; state reads as 0 immediately.
- Write latency: value visible on read ports in the same cycle via bypass, and from regs on every cycle after the commit edge.
- Read latency: 0 cycles (pure combinational from ReadRegisterN, regs, and WB inputs).
- No handshake; one write per cycle maximum; no stalls originate here.

## Test plan

- Reset: hold Rst=0, pulse Clk 3×, read all indices → ReadData1/2=0, CommitCount=0, LastWriteReg=0.
- Mux select: RegWrite_in=1, RtRd_in=5, ALUResult_in=0x11, ReadData_in=0x22, PC2ndAdder_in=0x33; MemReg_in=00/01/10/11 on successive edges → reg5 reads 0x11, 0x22, 0x33, 0x11; CommitCount=4.
- $zero protection: RegWrite_in=1, RtRd_in=0, ALUResult_in=0xDEADBEEF, one edge → ReadData1 at index 0 =0; CommitCount and LastWriteReg unchanged.
- Bypass: regs[8]=0xAAAA; present RegWrite_in=1, RtRd_in=8, ALUResult_in=0x5555, ReadRegister1=ReadRegister2=8 before the edge → both ports read 0x5555 pre-edge; after the edge, with RegWrite_in=0, they still read 0x5555.
- Index masking and disabled write: RtRd_in=0xFFFFFFE3, RegWrite_in=1, MemReg_in=01, ReadData_in=0x77 → reg3=0x77. Next cycle RegWrite_in=0, ALUResult_in=0x99 → reg3 stays 0x77 and the count is unchanged.
- Async reset mid-run: after several commits, drop Rst between clock edges → all reads go to 0 and CommitCount=0 before the next edge; first edge after release with RtRd_in=2, ALU 0x1 → CommitCount=1.
